nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder built around a single 4-bit carry-lookahead slice.
- Takes one nibble of each operand per cycle, LSB nibble first, and feeds it to the slice.
- The slice's carry-out becomes the next cycle's carry-in; each 4-bit sum is stored in a result register.
- Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake.
- Used where a full-width adder is too large and latency is acceptable.

---
 rtl/nibble_serial_adder.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice processes one
// nibble per cycle, LSB first, with valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  // Handshakes: a transfer happens on the rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE, so they never overlap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_next, nib_mask;
  logic             carry, cout_r, ovf_r, last;
  logic [IW-1:0]    idx;
  logic [3:0]       an, bn, g, p, s;
  logic [4:0]       c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    fsm_state = state;
  end

  // Carry-lookahead slice on the nibble selected by idx.
  always_comb begin
    an   = 4'(a_r >> {idx, 2'b00});
    bn   = 4'(b_r >> {idx, 2'b00});
    g    = an & bn;
    p    = an ^ bn;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s        = p ^ c[3:0];
    nib_mask = WIDTH'(4'hF) << {idx, 2'b00};
    sum_next = (sum_r & ~nib_mask) | (WIDTH'(s) << {idx, 2'b00});
    last     = (idx == IW'(NIB - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          carry <= cin;
          idx   <= '0;
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= c[4];
          if (last) begin
            cout_r <= c[4];
            // s[3] is the final sum MSB on the last nibble
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s[3] != a_r[WIDTH-1]);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed scenarios
// plus a randomized run, all checked against a full-width reference sum.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;
  logic [1:0]  fsm_state;

  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] vec_a[3]   = '{16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] vec_b[3]   = '{16'h0001, 16'h0001, 16'h8000};
  logic        vec_cin[3] = '{1'b0, 1'b0, 1'b0};

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from a full 17-bit addition.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] full;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + 17'(c);
    v    = (x[15] == y[15]) && (full[15] != x[15]);
    return {v, full};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and hold in_valid until accepted; pushes the expectation.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          output bit ok);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
    if (ok) exp_q.push_back(model(ta, tb_, tc));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, expected 1 0 0 0 0 0000",
               in_ready, out_valid, busy, cout, ovf, sum);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [17:0] e;
    start_op(16'h1234, 16'h4321, 1'b1, ok);
    n_checks++;
    if (!ok || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_accept: got ok=%b in_ready=%b busy=%b, expected 1 0 1", ok, in_ready, busy);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_run%0d: got out_valid=%b in_ready=%b, expected 0 0", k, out_valid, in_ready);
      end
    end
    tick();
    e = exp_q.size() > 0 ? exp_q.pop_front() : 18'h0;
    n_checks++;
    if (out_valid !== 1'b1 || {ovf, cout, sum} !== e || e !== {2'b00, 16'h5556}) begin
      n_fail++;
      $display("FAIL basic_result: got vld=%b {ovf,cout,sum}=%h, expected 1 %h", out_valid, {ovf, cout, sum}, 18'h05556);
    end
    finish_op();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h5556) begin
      n_fail++;
      $display("FAIL basic_exit: got in_ready=%b out_valid=%b sum=%h, expected 1 0 5556", in_ready, out_valid, sum);
    end
  endtask

  task automatic test_arith();
    bit ok;
    int cyc;
    logic [17:0] e;
    for (int i = 0; i < 3; i++) begin
      start_op(vec_a[i], vec_b[i], vec_cin[i], ok);
      wait_done(cyc);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 18'h0;
      n_checks++;
      if (!ok || cyc != 4 || {ovf, cout, sum} !== e) begin
        n_fail++;
        $display("FAIL arith%0d: got ok=%b latency=%0d {ovf,cout,sum}=%h, expected 1 4 %h",
                 i, ok, cyc, {ovf, cout, sum}, e);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [17:0] e;
    start_op(16'hABCD, 16'h1357, 1'b1, ok);
    wait_done(cyc);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 18'h0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== e) begin
        n_fail++;
        $display("FAIL stall%0d: got vld=%b rdy=%b {ovf,cout,sum}=%h, expected 1 0 %h",
                 k, out_valid, in_ready, {ovf, cout, sum}, e);
      end
      tick();
    end
    finish_op();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    start_op(16'h0F0F, 16'h00F1, 1'b0, ok);
    wait_done(cyc);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 18'h0;
    n_checks++;
    if (!ok || cyc != 4 || {ovf, cout, sum} !== {2'b00, 16'h1000} || e !== {2'b00, 16'h1000}) begin
      n_fail++;
      $display("FAIL stall_second: got latency=%0d {ovf,cout,sum}=%h, expected 4 01000", cyc, {ovf, cout, sum});
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    logic [17:0] e;
    start_op(16'hAAAA, 16'h5555, 1'b1, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    n_checks++;
    if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b sum=%h, expected 1 0 0 0000",
               in_ready, out_valid, busy, sum);
    end
    start_op(16'h0001, 16'h0002, 1'b0, ok);
    wait_done(cyc);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 18'h0;
    n_checks++;
    if (!ok || cyc != 4 || {ovf, cout, sum} !== {2'b00, 16'h0003} || e !== {2'b00, 16'h0003}) begin
      n_fail++;
      $display("FAIL reset_after: got latency=%0d {ovf,cout,sum}=%h, expected 4 00003", cyc, {ovf, cout, sum});
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int last_acc = -1;
    bit acc;
    logic [17:0] e;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && (n_acc < 5 || exp_q.size() > 0); cyc++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : 18'h0;
        n_checks++;
        if ({ovf, cout, sum} !== e) begin
          n_fail++;
          $display("FAIL b2b_result: got %h, expected %h", {ovf, cout, sum}, e);
        end
      end
      if (acc) begin
        exp_q.push_back(model(a, b, cin));
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != 6) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, expected 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      tick();
      if (acc) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
        if (n_acc >= 5) in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (n_acc != 5 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got accepts=%0d pending=%0d, expected 5 0", n_acc, exp_q.size());
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int recv = 0;
    int overlap = 0;
    bit acc, del;
    logic [17:0] e;
    for (int cyc = 0; cyc < 40000 && recv < 1000; cyc++) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready && out_valid) overlap++;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_unexpected: got %h, expected no output", {ovf, cout, sum});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== e) begin
            n_fail++;
            $display("FAIL rand_result%0d: got %h, expected %h", recv, {ovf, cout, sum}, e);
          end
        end
        recv++;
      end
      if (acc) begin
        exp_q.push_back(model(a, b, cin));
        sent++;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    n_checks++;
    if (recv != 1000 || overlap != 0) begin
      n_fail++;
      $display("FAIL rand_summary: got results=%0d overlap=%0d, expected 1000 0", recv, overlap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
